dpe_ingress_buf: RTL and testbench
==================================

Name: dpe_ingress_buf

Overview:
- Per-port store-and-forward ingress buffer between an Ethernet RX MAC (or CPU DMA) and one DPE `from_*` input.
- Accepts a non-backpressurable AXI-Stream from the MAC and holds each frame until it is complete and error-free.
- Presents only committed frames to the DPE. Stamps `tuser_src`, `tuser_dst` and the bypass bits.
- Drops errored and oversize/overflow frames and counts them.

Parameters:
- DATA_W, 128, tdata width in bits
- KEEP_W, DATA_W/8, tkeep width
- DEPTH, 512, buffer depth in words; power of 2, minimum 16
- SRC_ADDR, DPE_ADDR_ETH_1, value driven on m_tuser_src
- DST_ADDR, DPE_ADDR_CPU, default value driven on m_tuser_dst

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- s_tvalid  in  1  MAC beat valid
- s_tready  out  1  always 1 outside reset; the MAC cannot stall
- s_tdata  in  DATA_W  MAC data
- s_tkeep  in  KEEP_W  MAC byte enables
- s_tlast  in  1  last beat of frame
- s_tuser  in  1  frame error; sampled on the tlast beat
- m_tvalid  out  1  DPE-side valid
- m_tready  in  1  DPE-side ready
- m_tdata  out  DATA_W
- m_tkeep  out  KEEP_W
- m_tlast  out  1
- m_tuser_src  out  DPE_ADDR_W  equals SRC_ADDR
- m_tuser_dst  out  DPE_ADDR_W  equals DST_ADDR
- m_tuser_bypass_all  out  1  constant 0
- m_tuser_bypass_stage  out  1  constant 0
- pause  in  1  holds off the start of new output frames
- is_idle  out  1  no committed frames, no frame being written, output empty
- drop_cnt  out  16  dropped-frame counter
- ovf_cnt  out  16  overflow-drop counter

Behaviour:
- Storage: RAM of DEPTH x (DATA_W+KEEP_W+1).
- Pointers: write pointer wr_ptr, committed pointer cm_ptr, read pointer rd_ptr. All are log2(DEPTH)+1 bits, wrap naturally; full/empty use the MSB-compare rule.
- Reset (rst=0 at posedge): all pointers 0, write FSM to IDLE, frame count 0, m_tvalid=0, s_tready=0, counters 0, is_idle=1.
- s_tready=1 from the first cycle after reset release.
- Write FSM:
  - IDLE: s_tvalid beat → write the word, go to WR (stay in IDLE if the beat also has tlast and commits).
  - WR: each beat is written at wr_ptr and wr_ptr increments.
  - On the tlast beat with s_tuser=0: cm_ptr <= wr_ptr+1, frame count +1, back to IDLE.
  - On the tlast beat with s_tuser=1: wr_ptr <= cm_ptr, drop_cnt +1, back to IDLE.
  - Beat arrives while full (wr_ptr - rd_ptr == DEPTH): word is discarded, wr_ptr <= cm_ptr, ovf_cnt +1, go to DROP.
  - DROP: discard beats until the tlast beat, then IDLE. s_tuser is ignored in DROP.
  - Single-beat frame (tlast on the first beat) commits or drops in one cycle.
- Read side:
  - 1-deep output register with a RAM prefetch, giving full throughput: one beat per cycle while m_tready=1.
  - Latency from commit (tlast beat at edge N) to m_tvalid=1 is 2 cycles: m_tvalid=1 after edge N+2.
  - A frame starts only if frame count > 0 and pause=0. Once started, it streams to tlast regardless of pause.
  - On the m_tlast handshake, frame count decrements.
  - m_* signals are stable while m_tvalid=1 and m_tready=0 (AXI-S rule).
- Simultaneous commit and read-tlast in the same cycle: frame count is unchanged.
- Frames longer than DEPTH always end in overflow drop; there is no deadlock, because rd_ptr never passes cm_ptr.
- Counters saturate at 16'hFFFF.
- Reset mid-frame on either side discards everything; there is no partial output after reset.

Optional Feature:
- Macro: DPE_INGRESS_RUNT_FILTER_EN.
- Enabled: committed frames must have at least 4 beats. Shorter error-free frames are rewound like errors and counted in drop_cnt.
- Disabled: any length ≥1 is forwarded.

Decomposition:
- dpe_pkg holds:
  - DPE_ADDR_W and the DPE_ADDR_* constants
  - a dpe_beat_t struct {tdata, tkeep, tlast}
  - DPE_RUNT_MIN_BEATS=4
- Sub-module dpe_sdp_ram: simple dual-port, 1 write/1 read port, registered read, DEPTH x width parameters.

Test Plan:
1. Good 6-beat frame (tdata 01..06, tkeep all ones), m_tready=1 → m_tvalid 2 cycles after the s_tlast beat; 6 beats identical, tlast on beat 6; src=SRC_ADDR; drop_cnt=0.
2. 4-beat frame with s_tuser=1 on tlast, followed by a good 5-beat frame → only the 5-beat frame is output; drop_cnt=1.
3. DEPTH=16, 20-beat frame with m_tready=0 → ovf_cnt=1, nothing output; a following 3-beat frame is output intact.
4. Two committed frames, pause=1 → m_tvalid stays 0. Then pause=0 for one cycle and pause=1 again → the whole first frame is output, the second waits.
5. m_tready toggling 1,0,0,1,0,1… during a 6-beat frame → data/keep/last held stable while stalled, beat order preserved, frame count ends at 0, is_idle=1.
6. With DPE_INGRESS_RUNT_FILTER_EN: 2-beat good frame → dropped, drop_cnt=1. Without the macro: the same frame is forwarded.

Source files
------------

// File: rtl/dpe_pkg.sv
// rtl/dpe_pkg.sv - shared DPE address map, beat layout and ingress constants
package dpe_pkg;

  localparam int DPE_ADDR_W = 4;

  localparam logic [DPE_ADDR_W-1:0] DPE_ADDR_CPU   = 4'd0;
  localparam logic [DPE_ADDR_W-1:0] DPE_ADDR_ETH_0 = 4'd1;
  localparam logic [DPE_ADDR_W-1:0] DPE_ADDR_ETH_1 = 4'd2;
  localparam logic [DPE_ADDR_W-1:0] DPE_ADDR_ETH_2 = 4'd3;
  localparam logic [DPE_ADDR_W-1:0] DPE_ADDR_ETH_3 = 4'd4;

  localparam int DPE_DATA_W = 128;
  localparam int DPE_KEEP_W = DPE_DATA_W / 8;

  localparam int DPE_RUNT_MIN_BEATS = 4;

  typedef struct packed {
    logic [DPE_DATA_W-1:0] tdata;
    logic [DPE_KEEP_W-1:0] tkeep;
    logic                  tlast;
  } dpe_beat_t;

endpackage

// File: rtl/dpe_sdp_ram.sv
// rtl/dpe_sdp_ram.sv - simple dual-port RAM, one write and one registered read port
module dpe_sdp_ram #(
  parameter int DEPTH = 512,
  parameter int WIDTH = 145
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // rd_data holds its value while rd_en is low; the read pipeline relies on that to stall
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/dpe_ingress_buf.sv
// rtl/dpe_ingress_buf.sv - store-and-forward ingress buffer; DPE_INGRESS_RUNT_FILTER_EN enables runt drop
module dpe_ingress_buf
  import dpe_pkg::*;
#(
  parameter int                    DATA_W   = 128,
  parameter int                    KEEP_W   = DATA_W / 8,
  parameter int                    DEPTH    = 512,
  parameter logic [DPE_ADDR_W-1:0] SRC_ADDR = DPE_ADDR_ETH_1,
  parameter logic [DPE_ADDR_W-1:0] DST_ADDR = DPE_ADDR_CPU
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  input  logic [DATA_W-1:0]     s_tdata,
  input  logic [KEEP_W-1:0]     s_tkeep,
  input  logic                  s_tlast,
  input  logic                  s_tuser,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic [DATA_W-1:0]     m_tdata,
  output logic [KEEP_W-1:0]     m_tkeep,
  output logic                  m_tlast,
  output logic [DPE_ADDR_W-1:0] m_tuser_src,
  output logic [DPE_ADDR_W-1:0] m_tuser_dst,
  output logic                  m_tuser_bypass_all,
  output logic                  m_tuser_bypass_stage,
  input  logic                  pause,
  output logic                  is_idle,
  output logic [15:0]           drop_cnt,
  output logic [15:0]           ovf_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int WW = DATA_W + KEEP_W + 1;

  localparam logic [1:0] WS_IDLE = 2'd0;
  localparam logic [1:0] WS_WR   = 2'd1;
  localparam logic [1:0] WS_DROP = 2'd2;

  logic [PW-1:0] wr_ptr, cm_ptr, rd_ptr, fcnt;
  logic [1:0]    wstate;
  logic          ready_q;
  logic          beat, full, runt;
  logic          ram_we, commit, err_drop, ovf_drop;
  logic [WW-1:0] ram_rdata, out_word;
  logic          rd_en, a_vld, a_last, b_ready, cont, start, out_done;
  logic          m_tvalid_q;

  assign s_tready = ready_q;
  assign beat     = s_tvalid && ready_q;
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

`ifdef DPE_INGRESS_RUNT_FILTER_EN
  // wr_ptr - cm_ptr is the number of beats already stored for the open frame
  assign runt = (wr_ptr - cm_ptr) < PW'(DPE_RUNT_MIN_BEATS - 1);
`else
  assign runt = 1'b0;
`endif

  always_comb begin
    ram_we   = 1'b0;
    commit   = 1'b0;
    err_drop = 1'b0;
    ovf_drop = 1'b0;
    if (beat && wstate != WS_DROP) begin
      if (full) begin
        ovf_drop = 1'b1;
      end else begin
        ram_we = 1'b1;
        if (s_tlast) begin
          if (s_tuser || runt) err_drop = 1'b1;
          else                 commit   = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ready_q <= 1'b0;
      wr_ptr  <= '0;
      cm_ptr  <= '0;
      wstate  <= WS_IDLE;
    end else begin
      ready_q <= 1'b1;
      if (beat) begin
        if (wstate == WS_DROP) begin
          if (s_tlast) wstate <= WS_IDLE;
        end else if (ovf_drop) begin
          // an overflow on the tlast beat has nothing left to discard
          wr_ptr <= cm_ptr;
          wstate <= s_tlast ? WS_IDLE : WS_DROP;
        end else if (commit) begin
          wr_ptr <= wr_ptr + 1'b1;
          cm_ptr <= wr_ptr + 1'b1;
          wstate <= WS_IDLE;
        end else if (err_drop) begin
          wr_ptr <= cm_ptr;
          wstate <= WS_IDLE;
        end else begin
          wr_ptr <= wr_ptr + 1'b1;
          wstate <= WS_WR;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      drop_cnt <= '0;
      ovf_cnt  <= '0;
    end else begin
      if (err_drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      if (ovf_drop && ovf_cnt != 16'hFFFF)  ovf_cnt  <= ovf_cnt + 16'd1;
    end
  end

  dpe_sdp_ram #(
    .DEPTH (DEPTH),
    .WIDTH (WW)
  ) u_ram (
    .clk     (clk),
    .wr_en   (ram_we),
    .wr_addr (wr_ptr[AW-1:0]),
    .wr_data ({s_tlast, s_tkeep, s_tdata}),
    .rd_en   (rd_en),
    .rd_addr (rd_ptr[AW-1:0]),
    .rd_data (ram_rdata)
  );

  // Stage a is the RAM output register, stage b the output register. While a frame
  // is in flight, stage a always holds its most recently fetched word, so its tlast
  // tells whether to keep fetching or to consider starting the next frame.
  assign b_ready = !m_tvalid_q || m_tready;
  assign a_last  = ram_rdata[WW-1];
  assign cont    = a_vld && !a_last;
  assign start   = !cont && (fcnt != '0) && (rd_ptr != cm_ptr) && !pause;
  assign rd_en   = (!a_vld || b_ready) && (cont || start);

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr     <= '0;
      a_vld      <= 1'b0;
      m_tvalid_q <= 1'b0;
    end else begin
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      if (rd_en)        a_vld <= 1'b1;
      else if (b_ready) a_vld <= 1'b0;
      if (b_ready) m_tvalid_q <= a_vld;
    end
  end

  always_ff @(posedge clk) begin
    if (b_ready) out_word <= ram_rdata;
  end

  assign out_done = m_tvalid_q && m_tready && out_word[WW-1];

  always_ff @(posedge clk) begin
    if (!rst) begin
      fcnt <= '0;
    end else if (commit && !out_done) begin
      fcnt <= fcnt + 1'b1;
    end else if (out_done && !commit) begin
      fcnt <= fcnt - 1'b1;
    end
  end

  assign m_tvalid             = m_tvalid_q;
  assign m_tdata              = out_word[DATA_W-1:0];
  assign m_tkeep              = out_word[DATA_W +: KEEP_W];
  assign m_tlast              = out_word[WW-1];
  assign m_tuser_src          = SRC_ADDR;
  assign m_tuser_dst          = DST_ADDR;
  assign m_tuser_bypass_all   = 1'b0;
  assign m_tuser_bypass_stage = 1'b0;

  assign is_idle = (fcnt == '0) && (wstate == WS_IDLE) && !m_tvalid_q && !a_vld;

endmodule

// File: tb/tb_dpe_ingress_buf.sv
// tb/tb_dpe_ingress_buf.sv - directed self-checking bench for dpe_ingress_buf
module tb_dpe_ingress_buf;
  import dpe_pkg::*;

  localparam int DATA_W = 128;
  localparam int KEEP_W = 16;
  localparam int DEPTH  = 16;
`ifdef DPE_INGRESS_RUNT_FILTER_EN
  localparam int TAIL_N = 4;
`else
  localparam int TAIL_N = 3;
`endif

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  s_tvalid, s_tready, s_tlast, s_tuser;
  logic [DATA_W-1:0]     s_tdata;
  logic [KEEP_W-1:0]     s_tkeep;
  logic                  m_tvalid, m_tready, m_tlast;
  logic [DATA_W-1:0]     m_tdata;
  logic [KEEP_W-1:0]     m_tkeep;
  logic [DPE_ADDR_W-1:0] m_tuser_src, m_tuser_dst;
  logic                  m_tuser_bypass_all, m_tuser_bypass_stage;
  logic                  pause, is_idle;
  logic [15:0]           drop_cnt, ovf_cnt;

  int checks = 0;
  int errors = 0;
  int stall_err = 0;
  dpe_beat_t out_q[$];
  dpe_beat_t cur, prev_beat;
  logic prev_stall = 1'b0;

  always #5 clk = ~clk;

  dpe_ingress_buf #(
    .DATA_W (DATA_W),
    .KEEP_W (KEEP_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .s_tvalid             (s_tvalid),
    .s_tready             (s_tready),
    .s_tdata              (s_tdata),
    .s_tkeep              (s_tkeep),
    .s_tlast              (s_tlast),
    .s_tuser              (s_tuser),
    .m_tvalid             (m_tvalid),
    .m_tready             (m_tready),
    .m_tdata              (m_tdata),
    .m_tkeep              (m_tkeep),
    .m_tlast              (m_tlast),
    .m_tuser_src          (m_tuser_src),
    .m_tuser_dst          (m_tuser_dst),
    .m_tuser_bypass_all   (m_tuser_bypass_all),
    .m_tuser_bypass_stage (m_tuser_bypass_stage),
    .pause                (pause),
    .is_idle              (is_idle),
    .drop_cnt             (drop_cnt),
    .ovf_cnt              (ovf_cnt)
  );

  // Output monitor: records handshaken beats and flags any change during a stall
  always @(negedge clk) begin
    cur.tdata = m_tdata;
    cur.tkeep = m_tkeep;
    cur.tlast = m_tlast;
    if (!rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && (!m_tvalid || cur !== prev_beat)) stall_err++;
      prev_stall = m_tvalid && !m_tready;
      prev_beat  = cur;
      if (m_tvalid && m_tready) out_q.push_back(cur);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  function automatic dpe_beat_t mk_beat(input logic [7:0] base, input int i, input int n);
    dpe_beat_t b;
    b.tdata      = '0;
    b.tdata[7:0] = base + 8'(i);
    b.tkeep      = '1;
    b.tlast      = (i == n - 1);
    return b;
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int n, input logic [7:0] base, input logic err);
    for (int i = 0; i < n; i++) begin
      s_tvalid        = 1'b1;
      s_tdata         = '0;
      s_tdata[7:0]    = base + 8'(i);
      s_tkeep         = '1;
      s_tlast         = (i == n - 1);
      s_tuser         = err && (i == n - 1);
      step(1);
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    s_tuser  = 1'b0;
  endtask

  task automatic wait_beats(input int n, input int budget);
    for (int c = 0; c < budget && out_q.size() < n; c++) step(1);
  endtask

  task automatic test_reset;
    rst = 1'b0; s_tvalid = 1'b0; s_tdata = '0; s_tkeep = '0; s_tlast = 1'b0;
    s_tuser = 1'b0; m_tready = 1'b0; pause = 1'b0;
    step(3);
    @(negedge clk);
    checks++; if (s_tready !== 1'b0) begin errors++; $display("FAIL rst_tready got %b exp 0", s_tready); end
    checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL rst_tvalid got %b exp 0", m_tvalid); end
    checks++; if (is_idle !== 1'b1) begin errors++; $display("FAIL rst_idle got %b exp 1", is_idle); end
    checks++; if (drop_cnt !== 16'd0 || ovf_cnt !== 16'd0) begin
      errors++; $display("FAIL rst_cnt got %0d/%0d exp 0/0", drop_cnt, ovf_cnt);
    end
    step(1);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (s_tready !== 1'b0) begin errors++; $display("FAIL rel_tready0 got %b exp 0", s_tready); end
    @(negedge clk);
    checks++; if (s_tready !== 1'b1) begin errors++; $display("FAIL rel_tready1 got %b exp 1", s_tready); end
    step(1);
  endtask

  task automatic test_good_frame;
    m_tready = 1'b1;
    out_q.delete();
    send_frame(6, 8'h01, 1'b0);
    @(negedge clk);
    checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL lat_n0 got %b exp 0", m_tvalid); end
    @(negedge clk);
    checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL lat_n1 got %b exp 0", m_tvalid); end
    @(negedge clk);
    checks++; if (m_tvalid !== 1'b1) begin errors++; $display("FAIL lat_n2 got %b exp 1", m_tvalid); end
    checks++; if (m_tuser_src !== DPE_ADDR_ETH_1 || m_tuser_dst !== DPE_ADDR_CPU) begin
      errors++; $display("FAIL tuser_addr got %0d/%0d exp %0d/%0d", m_tuser_src, m_tuser_dst, DPE_ADDR_ETH_1, DPE_ADDR_CPU);
    end
    checks++; if (m_tuser_bypass_all !== 1'b0 || m_tuser_bypass_stage !== 1'b0) begin
      errors++; $display("FAIL bypass got %b%b exp 00", m_tuser_bypass_all, m_tuser_bypass_stage);
    end
    step(1);
    wait_beats(6, 40);
    step(5);
    checks++; if (out_q.size() !== 6) begin errors++; $display("FAIL good_len got %0d exp 6", out_q.size()); end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (out_q[i] !== mk_beat(8'h01, i, 6)) begin
        errors++; $display("FAIL good_beat%0d got %h exp %h", i, out_q[i], mk_beat(8'h01, i, 6));
      end
    end
    checks++; if (drop_cnt !== 16'd0) begin errors++; $display("FAIL good_drop got %0d exp 0", drop_cnt); end
  endtask

  task automatic test_error_drop;
    m_tready = 1'b1;
    out_q.delete();
    send_frame(4, 8'h10, 1'b1);
    send_frame(5, 8'h20, 1'b0);
    wait_beats(5, 40);
    step(10);
    checks++; if (out_q.size() !== 5) begin errors++; $display("FAIL err_len got %0d exp 5", out_q.size()); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (out_q[i] !== mk_beat(8'h20, i, 5)) begin
        errors++; $display("FAIL err_beat%0d got %h exp %h", i, out_q[i], mk_beat(8'h20, i, 5));
      end
    end
    checks++; if (drop_cnt !== 16'd1) begin errors++; $display("FAIL err_drop got %0d exp 1", drop_cnt); end
  endtask

  task automatic test_overflow;
    m_tready = 1'b0;
    out_q.delete();
    send_frame(20, 8'h40, 1'b0);
    step(4);
    @(negedge clk);
    checks++; if (ovf_cnt !== 16'd1) begin errors++; $display("FAIL ovf_cnt got %0d exp 1", ovf_cnt); end
    checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL ovf_tvalid got %b exp 0", m_tvalid); end
    checks++; if (is_idle !== 1'b1) begin errors++; $display("FAIL ovf_idle got %b exp 1", is_idle); end
    step(1);
    send_frame(TAIL_N, 8'h60, 1'b0);
    step(3);
    @(negedge clk);
    checks++; if (m_tvalid !== 1'b1 || m_tdata[7:0] !== 8'h60) begin
      errors++; $display("FAIL tail_head got v=%b d=%h exp v=1 d=60", m_tvalid, m_tdata[7:0]);
    end
    step(1);
    m_tready = 1'b1;
    wait_beats(TAIL_N, 40);
    step(5);
    checks++; if (out_q.size() !== TAIL_N) begin errors++; $display("FAIL tail_len got %0d exp %0d", out_q.size(), TAIL_N); end
    for (int i = 0; i < TAIL_N; i++) begin
      checks++;
      if (out_q[i] !== mk_beat(8'h60, i, TAIL_N)) begin
        errors++; $display("FAIL tail_beat%0d got %h exp %h", i, out_q[i], mk_beat(8'h60, i, TAIL_N));
      end
    end
    checks++; if (ovf_cnt !== 16'd1) begin errors++; $display("FAIL ovf_after got %0d exp 1", ovf_cnt); end
  endtask

  task automatic test_pause;
    m_tready = 1'b1;
    pause    = 1'b1;
    out_q.delete();
    send_frame(4, 8'h80, 1'b0);
    send_frame(4, 8'h90, 1'b0);
    step(8);
    @(negedge clk);
    checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL pause_hold got %b exp 0", m_tvalid); end
    checks++; if (is_idle !== 1'b0) begin errors++; $display("FAIL pause_idle got %b exp 0", is_idle); end
    step(1);
    pause = 1'b0;
    step(1);
    pause = 1'b1;
    wait_beats(4, 30);
    step(10);
    @(negedge clk);
    checks++; if (out_q.size() !== 4) begin errors++; $display("FAIL pause_len got %0d exp 4", out_q.size()); end
    checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL pause_second got %b exp 0", m_tvalid); end
    step(1);
    pause = 1'b0;
    wait_beats(8, 30);
    step(5);
    checks++; if (out_q.size() !== 8) begin errors++; $display("FAIL pause_total got %0d exp 8", out_q.size()); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (out_q[i] !== mk_beat((i < 4) ? 8'h80 : 8'h90, i % 4, 4)) begin
        errors++; $display("FAIL pause_beat%0d got %h exp %h", i, out_q[i], mk_beat((i < 4) ? 8'h80 : 8'h90, i % 4, 4));
      end
    end
  endtask

  task automatic test_stall;
    logic [11:0] pat;
    pat = 12'b1010_0110_1001;
    m_tready = 1'b0;
    out_q.delete();
    send_frame(6, 8'hA0, 1'b0);
    step(3);
    for (int k = 11; k >= 0; k--) begin
      m_tready = pat[k];
      step(1);
    end
    m_tready = 1'b1;
    wait_beats(6, 40);
    step(5);
    @(negedge clk);
    checks++; if (out_q.size() !== 6) begin errors++; $display("FAIL stall_len got %0d exp 6", out_q.size()); end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (out_q[i] !== mk_beat(8'hA0, i, 6)) begin
        errors++; $display("FAIL stall_beat%0d got %h exp %h", i, out_q[i], mk_beat(8'hA0, i, 6));
      end
    end
    checks++; if (stall_err !== 0) begin errors++; $display("FAIL stall_stable got %0d exp 0", stall_err); end
    checks++; if (is_idle !== 1'b1) begin errors++; $display("FAIL stall_idle got %b exp 1", is_idle); end
    step(1);
  endtask

  task automatic test_runt;
    m_tready = 1'b1;
    out_q.delete();
    send_frame(2, 8'hC0, 1'b0);
    step(12);
`ifdef DPE_INGRESS_RUNT_FILTER_EN
    checks++; if (out_q.size() !== 0) begin errors++; $display("FAIL runt_len got %0d exp 0", out_q.size()); end
    checks++; if (drop_cnt !== 16'd2) begin errors++; $display("FAIL runt_drop got %0d exp 2", drop_cnt); end
`else
    checks++; if (out_q.size() !== 2) begin errors++; $display("FAIL runt_len got %0d exp 2", out_q.size()); end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (out_q[i] !== mk_beat(8'hC0, i, 2)) begin
        errors++; $display("FAIL runt_beat%0d got %h exp %h", i, out_q[i], mk_beat(8'hC0, i, 2));
      end
    end
    checks++; if (drop_cnt !== 16'd1) begin errors++; $display("FAIL runt_drop got %0d exp 1", drop_cnt); end
`endif
  endtask

  task automatic test_reset_mid_frame;
    m_tready = 1'b0;
    send_frame(4, 8'hE0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      s_tvalid     = 1'b1;
      s_tdata      = '0;
      s_tdata[7:0] = 8'hF0 + 8'(i);
      s_tkeep      = '1;
      s_tlast      = 1'b0;
      step(1);
    end
    s_tvalid = 1'b0;
    out_q.delete();
    rst = 1'b0;
    step(2);
    rst = 1'b1;
    step(1);
    m_tready = 1'b1;
    step(10);
    @(negedge clk);
    checks++; if (out_q.size() !== 0) begin errors++; $display("FAIL mid_len got %0d exp 0", out_q.size()); end
    checks++; if (is_idle !== 1'b1 || m_tvalid !== 1'b0) begin
      errors++; $display("FAIL mid_idle got idle=%b v=%b exp 1/0", is_idle, m_tvalid);
    end
    checks++; if (drop_cnt !== 16'd0 || ovf_cnt !== 16'd0) begin
      errors++; $display("FAIL mid_cnt got %0d/%0d exp 0/0", drop_cnt, ovf_cnt);
    end
    step(1);
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_error_drop();
    test_overflow();
    test_pause();
    test_stall();
    test_runt();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
